// File: rtl/button_input_pio_pkg.sv
// Shared constants for the button/switch input PIO.
// Register addresses, edge-type encodings and counter sizing.
package pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int PIO_EDGE_RISE = 0;
    localparam int PIO_EDGE_FALL = 1;
    localparam int PIO_EDGE_ANY  = 2;

    function automatic int pio_cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_input_pio_if.sv
// Avalon-MM slave bus bundle for the input PIO.
// Word address, select, write strobe and 32-bit data.
interface button_input_pio_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/pio_debounce_bit.sv
// One input bit: 2-flop synchronizer followed by a stable-count debouncer.
// The count restarts whenever the synchronized input matches the accepted level.
module pio_debounce_bit
    import pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit RST_LVL         = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic deb
);

    localparam int CW = pio_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RST_LVL;
            sync2 <= RST_LVL;
            deb   <= RST_LVL;
            cnt   <= '0;
        end else begin
            sync1 <= in_bit;
            sync2 <= sync1;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_input_pio.sv
// Avalon-MM input PIO: debounced level, edge capture with W1C, masked irq.
// Read data is registered every cycle from the current address.
module button_input_pio
    import pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    button_input_pio_if.slave    bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    // Active-low buttons idle high, so the falling-edge build resets to 1s.
    localparam bit RST_LVL = (EDGE_TYPE == PIO_EDGE_FALL);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] clr_vec;
    logic [31:0]      rd_next;
    logic             wr;
    logic             unused_wd;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_LVL         (RST_LVL)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .in_bit  (in_port[i]),
            .deb     (deb[i])
        );
    end

    if (EDGE_TYPE == PIO_EDGE_RISE) begin : g_rise
        assign edge_vec = deb & ~deb_d;
    end else if (EDGE_TYPE == PIO_EDGE_FALL) begin : g_fall
        assign edge_vec = ~deb & deb_d;
    end else begin : g_any
        assign edge_vec = deb ^ deb_d;
    end

    assign wr        = bus.chipselect & ~bus.write_n;
    assign unused_wd = ^bus.writedata;
    assign clr_vec   = (wr && bus.address == PIO_ADDR_EDGECAP)
                     ? bus.writedata[WIDTH-1:0] : '0;
    assign irq       = |(edgecap & irqmask);

    always_comb begin
        rd_next = '0;
        unique case (1'b1)
            (bus.address == PIO_ADDR_DATA):    rd_next[WIDTH-1:0] = deb;
            (bus.address == PIO_ADDR_DIR):     rd_next = '0;
            (bus.address == PIO_ADDR_IRQMASK): rd_next[WIDTH-1:0] = irqmask;
            (bus.address == PIO_ADDR_EDGECAP): rd_next[WIDTH-1:0] = edgecap;
        endcase
    end

    // New edges are OR'd in after the clear so a same-cycle set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_d        <= {WIDTH{RST_LVL}};
            irqmask      <= '0;
            edgecap      <= '0;
            bus.readdata <= '0;
        end else begin
            deb_d        <= deb;
            edgecap      <= (edgecap & ~clr_vec) | edge_vec;
            bus.readdata <= rd_next;
            if (wr && bus.address == PIO_ADDR_IRQMASK) begin
                irqmask <= bus.writedata[WIDTH-1:0];
            end
        end
    end

endmodule

// File: doc/button_input_pio.md
# button_input_pio

Avalon-MM slave input port for the basic system's push-buttons and switches, the read-side counterpart of the 4-bit LED output port. It synchronizes and debounces the external `in_port` lines, latches edges per bit, and raises a level interrupt to the Nios II processor. It sits on the system interconnect beside the LED port, using the same 2-bit word address and 32-bit data bus.

## Interface
- `WIDTH`, default 4: number of input bits, range 1..32.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a new level, range 1..2^20.
- `EDGE_TYPE`, default 1: edge-capture polarity. 0 = rising, 1 = falling, 2 = any.
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `address`, in, 2: word address.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe.
- `writedata`, in, 32: write data.
- `readdata`, out, 32: registered read data.
- `in_port`, in, WIDTH: asynchronous external inputs.
- `irq`, out, 1: level interrupt request, active-high.

## Operation
- **Register map.** Bits above WIDTH always read 0.
  - Address 0 `DATA`: read-only, returns the debounced level. Writes are ignored.
  - Address 1: reserved. Reads 0, writes ignored.
  - Address 2 `IRQMASK`: read/write, WIDTH bits.
  - Address 3 `EDGECAP`: a read returns the captured edges. A write clears every bit written as 1 (write-1-to-clear) and leaves bits written as 0 unchanged.
- **Synchronizer.** A 2-flop chain per bit: `sync1` then `sync2`.
- **Debounce**, per bit, using counter `cnt` of width clog2(DEBOUNCE_CYCLES) (minimum 1). On each clock edge:
  - If `sync2` == `deb`: `cnt` <= 0.
  - Else if `cnt` == DEBOUNCE_CYCLES-1: `deb` <= `sync2` and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - Any single cycle where `sync2` equals `deb` restarts the count. A glitch shorter than DEBOUNCE_CYCLES therefore never reaches `deb`.
- **Edge detect.** `deb_d` <= `deb` every cycle. The edge vector is selected by EDGE_TYPE:
  - rising: `deb` & ~`deb_d`
  - falling: ~`deb` & `deb_d`
  - any: `deb` ^ `deb_d`
- **Edge capture.** On each edge, every `EDGECAP` bit whose edge-vector bit is 1 is set. It is cleared only by a write-1-to-clear access.
- **Simultaneous clear and new edge on the same bit:** the set wins and the bit stays 1.
- **Interrupt.** `irq` = OR-reduction of (`EDGECAP` & `IRQMASK`). This is combinational from registers, with no extra delay.
- **Write qualification.** A write takes effect when `chipselect` & ~`write_n` at a clock edge.
- **Read path.** `readdata` <= mux(`address`) on every clock edge, regardless of `chipselect`.

## Timing
- **Reset values:**
  - `readdata` = 0 and `irq` = 0.
  - `sync1`, `sync2`, `deb` and `deb_d` all reset to 1 when EDGE_TYPE = 1 (active-low buttons), and to 0 otherwise.
  - `cnt` = 0, `IRQMASK` = 0, `EDGECAP` = 0.
- **Reset mid-operation** (`reset_n` asserted asynchronously) returns every register to its reset value immediately.
  - Any partial debounce count is discarded.
  - Any pending interrupt drops within the same cycle.
- **Read latency is fixed at 1 cycle.** `address` sampled at edge N gives `readdata` valid after edge N+1. There is no wait-state.
- **Input-to-level latency.** With `in_port` changed before edge E0 and held stable:
  - `sync2` updates at E1.
  - `deb` updates at E(1+DEBOUNCE_CYCLES).
  - `EDGECAP` bit sets at E(2+DEBOUNCE_CYCLES).
  - `irq` rises at that same edge if the bit is masked in.
- **Write latency.** An `IRQMASK` write at edge N changes `irq` after edge N, in the same cycle the register updates.
- **Back-to-back accesses** are allowed on every cycle.

## Structure
- **Package `pio_pkg`:**
  - Address constants `PIO_ADDR_DATA`=0, `PIO_ADDR_DIR`=1, `PIO_ADDR_IRQMASK`=2, `PIO_ADDR_EDGECAP`=3.
  - EDGE_TYPE encodings `PIO_EDGE_RISE`/`FALL`/`ANY`.
  - Counter-width function.
- **Sub-module `pio_debounce_bit`:** one per input bit, holding the sync chain, `cnt` and `deb`. It is instantiated WIDTH times in a generate loop.
- **Top-level:** edge detection, registers, read mux and `irq`.

## Test plan
All cases use WIDTH=4, DEBOUNCE_CYCLES=4 and EDGE_TYPE=1 unless stated.
- **Reset check:** reset, then read address 0. Expect `readdata`=0x0000000F and `irq`=0.
- **Glitch rejection:** drive `in_port`=4'b1110 for 3 cycles, then back to 1111. Expect `DATA` to stay 0xF and `EDGECAP`=0.
- **Clean press:** hold `in_port`=4'b1110 from E0.
  - Expect `DATA` bit0 = 0 after E5.
  - Expect `EDGECAP`=0x1 after E6.
  - With `IRQMASK`=0x1, expect `irq`=1 at E6.
- **Interrupt clear:** write 0x1 to address 3. Expect `EDGECAP`=0 and `irq`=0 after that edge.
  - Then write 0x0 to address 3 with bit1 captured. Expect bit1 to remain set.
- **Clear/set race:** write 0x1 to address 3 on the same edge bit0 captures a new falling edge. Expect bit0 to stay 1.
- **Reset mid-count:** assert `reset_n`=0 while `cnt`=2. Expect `irq`=0 immediately, `DATA` back to 0xF, and debouncing to restart from 0 after release.
